imu_spi_sampler: RTL and testbench
==================================

Name: imu_spi_sampler

Overview:
- Upstream data source for the IMU AXI4-Lite register slave.
- Periodically burst-reads the 14 sensor bytes (accel XYZ, temp, gyro XYZ, big-endian 16-bit each) from an MPU-9250-class IMU over 4-wire SPI, mode 3.
- Packs the bytes plus a sample counter into four 32-bit words.
- Presents the words atomically with a one-cycle data_valid strobe; the register slave copies them into its four read registers.

Parameters:
- CLK_DIV, 10: ACLK cycles per SCLK half-period; legal range 2..255.
- SAMPLE_PERIOD, 100000: ACLK cycles between sample triggers; minimum 2.
- START_ADDR, 8'h3B: first IMU register address of the burst.

Ports:
- ACLK  in  1  system clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- enable  in  1  sampling enable, from the control register.
- spi_sclk  out  1  SPI clock; idles high.
- spi_cs_n  out  1  SPI chip select, active low.
- spi_mosi  out  1  SPI master-out data.
- spi_miso  in  1  SPI master-in data.
- data_out0  out  32  {accel_x, accel_y}
- data_out1  out  32  {accel_z, temp}
- data_out2  out  32  {gyro_x, gyro_y}
- data_out3  out  32  {gyro_z, sample_cnt[15:0]}
- data_valid  out  1  one-cycle pulse when data_out0..3 update.
- busy  out  1  high from trigger cycle through the UPDATE cycle.

Behaviour:
- Reset values:
  - spi_sclk=1, spi_cs_n=1, spi_mosi=1.
  - data_out0..3=0, data_valid=0, busy=0.
  - sample_cnt=0, timer=0, state=IDLE.
  - Reset takes effect in the cycle it is sampled, including mid-transaction: CS deasserts immediately and no partial update is made.
- Timer:
  - While enable=1, counts 0..SAMPLE_PERIOD-1 and wraps.
  - Trigger asserts in the cycle timer==SAMPLE_PERIOD-1.
  - enable=0 clears the timer to 0 and blocks triggers.
  - A trigger while busy=1 is dropped; the timer keeps running.
- FSM: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> UPDATE -> IDLE.
  - IDLE: on trigger (cycle T), go to CS_SETUP. busy=1 from cycle T.
  - CS_SETUP: spi_cs_n=0 from T+1; lasts CLK_DIV cycles; sclk stays high.
  - SHIFT: 15 bytes = 120 bits, MSB first.
    - Each bit is CLK_DIV cycles sclk low, then CLK_DIV cycles sclk high.
    - MOSI changes on the falling edge; MISO is sampled in the ACLK cycle sclk rises.
    - Byte 0 on MOSI = 8'h80 | START_ADDR (read bit set). Bytes 1..14 on MOSI = 8'h00.
    - MISO during byte 0 is ignored. Bytes 1..14 are shifted into a 112-bit buffer.
    - Duration is 240*CLK_DIV cycles.
  - CS_HOLD: sclk high, cs_n low, for CLK_DIV cycles. spi_cs_n returns to 1 on entry to UPDATE.
  - UPDATE (1 cycle):
    - data_out0..3 load simultaneously from the buffer, with sample_cnt+1 in data_out3[15:0].
    - sample_cnt increments; wraps 16'hFFFF -> 0.
    - data_valid=1 for this cycle only. busy=1 this cycle and 0 afterwards.
- Timing: data_valid is asserted at cycle T+1+242*CLK_DIV.
- Byte mapping: byte1 -> data_out0[31:24]; bytes proceed downward through data_out0..data_out3[31:16]; byte14 -> data_out3[23:16].
- Data hold: data_out0..3 hold their value between updates and are never partially updated.
- enable falling mid-transaction: the current transaction completes and updates normally; no further trigger occurs.
- Simultaneous trigger and UPDATE: the trigger is dropped (busy=1).

Test Plan:
- CLK_DIV=2, SAMPLE_PERIOD=1000, enable=1 from reset release; SPI slave model returns bytes 8'h01..8'h0E:
  - First data_valid occurs at trigger+485.
  - data_out0=32'h01020304, data_out1=32'h05060708, data_out2=32'h090A0B0C, data_out3=32'h0D0E0001.
- Same setup, monitor MOSI in byte 0: MOSI byte 0 = 8'hBB; bytes 1..14 are 0x00.
  - SCLK high phase = 2 cycles, low phase = 2 cycles.
  - Exactly 120 rising edges while cs_n=0.
- SAMPLE_PERIOD=300 (shorter than a 485-cycle transaction):
  - Every other trigger is dropped.
  - Consecutive data_valid pulses are 600 cycles apart.
  - sample_cnt increments by 1 per pulse.
- Assert ARESET at SHIFT bit 50:
  - Next cycle: cs_n=1, sclk=1, data_out0..3=0, busy=0.
  - No data_valid is produced.
- Drop enable mid-SHIFT:
  - The transaction completes with one data_valid.
  - No further cs_n activity for 3*SAMPLE_PERIOD cycles.
- Preload sample_cnt to 16'hFFFF via 65535 forced samples (or a hierarchical force), then one more sample: data_out3[15:0] wraps to 16'h0000.

Source files
------------

// File: rtl/imu_spi_sampler.sv
// Periodic SPI mode-3 burst reader for a 14-byte IMU sensor block.
// Publishes the bytes plus a sample counter as four 32-bit words.
module imu_spi_sampler #(
  parameter int          CLK_DIV       = 10,
  parameter int          SAMPLE_PERIOD = 100000,
  parameter logic [7:0]  START_ADDR    = 8'h3B
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        enable,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [31:0] data_out0,
  output logic [31:0] data_out1,
  output logic [31:0] data_out2,
  output logic [31:0] data_out3,
  output logic        data_valid,
  output logic        busy
);

  localparam int              TW   = $clog2(SAMPLE_PERIOD);
  localparam logic [TW-1:0]   TMAX = TW'(SAMPLE_PERIOD - 1);
  localparam logic [7:0]      DMAX = 8'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;

  logic [TW-1:0]  r_timer;
  logic [2:0]     r_state;
  logic [7:0]     r_div;
  logic           r_phase;
  logic [6:0]     r_bit;
  logic [7:0]     r_tx;
  logic [111:0]   r_rx;
  logic [15:0]    r_sample_cnt;
  logic           r_sclk;
  logic           r_cs_n;
  logic           r_mosi;
  logic           r_valid;
  logic [31:0]    r_d0, r_d1, r_d2, r_d3;

  logic w_trig;
  logic w_start;
  logic w_div_end;

  assign w_trig    = enable && (r_timer == TMAX);
  assign w_start   = w_trig && (r_state == S_IDLE);
  assign w_div_end = (r_div == DMAX);

  assign spi_sclk   = r_sclk;
  assign spi_cs_n   = r_cs_n;
  assign spi_mosi   = r_mosi;
  assign data_out0  = r_d0;
  assign data_out1  = r_d1;
  assign data_out2  = r_d2;
  assign data_out3  = r_d3;
  assign data_valid = r_valid;
  // Busy covers the trigger cycle itself so a trigger landing in UPDATE is dropped.
  assign busy       = (r_state != S_IDLE) || w_trig;

  always_ff @(posedge ACLK) begin
    if (ARESET)                      r_timer <= '0;
    else if (!enable || w_trig)      r_timer <= '0;
    else                             r_timer <= r_timer + 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state      <= S_IDLE;
      r_div        <= '0;
      r_phase      <= 1'b0;
      r_bit        <= '0;
      r_tx         <= '0;
      r_rx         <= '0;
      r_sample_cnt <= '0;
      r_sclk       <= 1'b1;
      r_cs_n       <= 1'b1;
      r_mosi       <= 1'b1;
      r_valid      <= 1'b0;
      r_d0         <= '0;
      r_d1         <= '0;
      r_d2         <= '0;
      r_d3         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_SETUP;
            r_cs_n  <= 1'b0;
            r_div   <= '0;
            r_phase <= 1'b0;
            r_bit   <= '0;
            r_tx    <= 8'h80 | START_ADDR;
          end
        end
        S_SETUP: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_state <= S_SHIFT;
            r_sclk  <= 1'b0;
            r_mosi  <= r_tx[7];
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        S_SHIFT: begin
          if (!w_div_end) begin
            r_div <= r_div + 8'd1;
          end else begin
            r_div <= '0;
            if (!r_phase) begin
              // Rising edge: capture MISO, skipping the command byte.
              r_phase <= 1'b1;
              r_sclk  <= 1'b1;
              if (r_bit >= 7'd8) r_rx <= {r_rx[110:0], spi_miso};
            end else if (r_bit == 7'd119) begin
              r_state <= S_HOLD;
              r_mosi  <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              r_sclk  <= 1'b0;
              r_bit   <= r_bit + 7'd1;
              r_tx    <= {r_tx[6:0], 1'b0};
              r_mosi  <= r_tx[6];
            end
          end
        end
        S_HOLD: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_state <= S_UPDATE;
            r_cs_n  <= 1'b1;
            r_valid <= 1'b1;
            r_d0    <= r_rx[111:80];
            r_d1    <= r_rx[79:48];
            r_d2    <= r_rx[47:16];
            r_d3    <= {r_rx[15:0], r_sample_cnt + 16'd1};
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        S_UPDATE: begin
          r_valid      <= 1'b0;
          r_sample_cnt <= r_sample_cnt + 16'd1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imu_spi_sampler.sv
// Directed bench: two sampler instances (long and short sample period) with SPI slave models.
module tb_imu_spi_sampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, en_a = 1'b0, miso_a = 1'b0;
  logic        sclk_a, cs_a, mosi_a, valid_a, busy_a;
  logic [31:0] d0_a, d1_a, d2_a, d3_a;

  logic        rst_b = 1'b1, en_b = 1'b0, miso_b = 1'b0;
  logic        sclk_b, cs_b, mosi_b, valid_b, busy_b;
  logic [31:0] d0_b, d1_b, d2_b, d3_b;

  imu_spi_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(1000), .START_ADDR(8'h3B)) dut_a (
    .ACLK(clk), .ARESET(rst_a), .enable(en_a),
    .spi_sclk(sclk_a), .spi_cs_n(cs_a), .spi_mosi(mosi_a), .spi_miso(miso_a),
    .data_out0(d0_a), .data_out1(d1_a), .data_out2(d2_a), .data_out3(d3_a),
    .data_valid(valid_a), .busy(busy_a));

  imu_spi_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(300), .START_ADDR(8'h3B)) dut_b (
    .ACLK(clk), .ARESET(rst_b), .enable(en_b),
    .spi_sclk(sclk_b), .spi_cs_n(cs_b), .spi_mosi(mosi_b), .spi_miso(miso_b),
    .data_out0(d0_b), .data_out1(d1_b), .data_out2(d2_b), .data_out3(d3_b),
    .data_valid(valid_b), .busy(busy_b));

  typedef struct {
    logic [111:0] payload;
    logic [31:0]  e0, e1, e2, e3;
  } vec_t;
  vec_t vecs[3];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit b_done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // SPI slave A: shifts {dummy, payload} out on falling SCLK; captures MOSI on rising SCLK.
  logic [111:0] payload_a;
  logic [119:0] mosi_cap;
  int           tx_idx, rise_cnt;

  always @(negedge cs_a) begin
    tx_idx   = 0;
    rise_cnt = 0;
    mosi_cap = '0;
  end

  always @(negedge sclk_a) begin
    if (!cs_a) begin
      logic [119:0] stream;
      stream = {8'h00, payload_a};
      if (tx_idx < 120) miso_a = stream[119 - tx_idx];
      tx_idx++;
    end
  end

  always @(posedge sclk_a) begin
    if (!cs_a) begin
      mosi_cap = {mosi_cap[118:0], mosi_a};
      rise_cnt++;
    end
  end

  // SCLK phase-length monitor over each CS-low window.
  bit   in_tx = 1'b0;
  logic prev_sclk;
  int   run, lo_min, lo_max, hi_min, hi_max;
  always @(negedge clk) begin
    if (!cs_a) begin
      if (!in_tx) begin
        in_tx = 1'b1; run = 1; prev_sclk = sclk_a;
        lo_min = 999; lo_max = 0; hi_min = 999; hi_max = 0;
      end else if (sclk_a == prev_sclk) begin
        run++;
      end else begin
        if (prev_sclk == 1'b0) begin
          if (run < lo_min) lo_min = run;
          if (run > lo_max) lo_max = run;
        end else begin
          if (run < hi_min) hi_min = run;
          if (run > hi_max) hi_max = run;
        end
        run = 1; prev_sclk = sclk_a;
      end
    end else begin
      in_tx = 1'b0;
    end
  end

  // 0: valid_a, 1: busy_a, 2: cs_a low, 3: >=50 SCLK rises in current frame
  task automatic wait_for(input int which, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      case (which)
        0: ok = valid_a;
        1: ok = busy_a;
        2: ok = !cs_a;
        default: ok = (rise_cnt >= 50) && !cs_a;
      endcase
      if (ok) return;
    end
  endtask

  initial begin
    bit ok;
    int t0, cnt;

    vecs[0] = '{112'h0102030405060708090A0B0C0D0E,
                32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0001};
    vecs[1] = '{112'hFFEEDDCCBBAA99887766554433_22,
                32'hFFEEDDCC, 32'hBBAA9988, 32'h77665544, 32'h33220002};
    vecs[2] = '{112'h800000017FFFFFFE00001234ABCD,
                32'h80000001, 32'h7FFFFFFE, 32'h00001234, 32'hABCD0003};
    payload_a = vecs[0].payload;

    en_a = 1'b1;
    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sclk",  sclk_a, 1'b1);
    chk("rst_cs_n",  cs_a, 1'b1);
    chk("rst_mosi",  mosi_a, 1'b1);
    chk("rst_d0",    d0_a, 32'h0);
    chk("rst_d1",    d1_a, 32'h0);
    chk("rst_d2",    d2_a, 32'h0);
    chk("rst_d3",    d3_a, 32'h0);
    chk("rst_valid", valid_a, 1'b0);
    chk("rst_busy",  busy_a, 1'b0);
    rst_a = 1'b0;

    for (int i = 0; i < 3; i++) begin
      payload_a = vecs[i].payload;
      wait_for(1, 2000, ok);
      chk($sformatf("v%0d_trigger_seen", i), ok, 1'b1);
      t0 = cyc;
      wait_for(0, 600, ok);
      chk($sformatf("v%0d_valid_seen", i), ok, 1'b1);
      chk($sformatf("v%0d_latency", i), cyc - t0, 485);
      chk($sformatf("v%0d_d0", i), d0_a, vecs[i].e0);
      chk($sformatf("v%0d_d1", i), d1_a, vecs[i].e1);
      chk($sformatf("v%0d_d2", i), d2_a, vecs[i].e2);
      chk($sformatf("v%0d_d3", i), d3_a, vecs[i].e3);
      chk($sformatf("v%0d_mosi_cmd", i), mosi_cap[119:112], 8'hBB);
      chk($sformatf("v%0d_mosi_pad", i), mosi_cap[111:0], 112'h0);
      chk($sformatf("v%0d_rises", i), rise_cnt, 120);
      chk($sformatf("v%0d_lo_min", i), lo_min, 2);
      chk($sformatf("v%0d_lo_max", i), lo_max, 2);
      chk($sformatf("v%0d_hi_min", i), hi_min, 2);
      chk($sformatf("v%0d_hi_max", i), hi_max, 2);
      @(negedge clk);
      chk($sformatf("v%0d_valid_pulse", i), valid_a, 1'b0);
      chk($sformatf("v%0d_busy_drop", i), busy_a, 1'b0);
    end

    // Reset during SHIFT around bit 50.
    wait_for(3, 2000, ok);
    chk("mid_rst_reached_shift", ok, 1'b1);
    rst_a = 1'b1;
    @(negedge clk);
    chk("mid_rst_cs_n", cs_a, 1'b1);
    chk("mid_rst_sclk", sclk_a, 1'b1);
    chk("mid_rst_d0", d0_a, 32'h0);
    chk("mid_rst_d1", d1_a, 32'h0);
    chk("mid_rst_d2", d2_a, 32'h0);
    chk("mid_rst_d3", d3_a, 32'h0);
    chk("mid_rst_busy", busy_a, 1'b0);
    rst_a = 1'b0;
    cnt = 0;
    repeat (900) begin
      @(negedge clk);
      if (valid_a) cnt++;
    end
    chk("mid_rst_no_valid", cnt, 0);

    // Drop enable in the middle of SHIFT.
    wait_for(3, 2000, ok);
    chk("en_drop_reached_shift", ok, 1'b1);
    en_a = 1'b0;
    wait_for(0, 600, ok);
    chk("en_drop_valid_seen", ok, 1'b1);
    chk("en_drop_d0", d0_a, 32'h80000001);
    chk("en_drop_d3", d3_a, 32'hABCD0001);
    cnt = 0;
    repeat (3000) begin
      @(negedge clk);
      if (!cs_a) cnt++;
    end
    chk("en_drop_cs_quiet", cnt, 0);

    // Sample counter wrap.
    force dut_a.r_sample_cnt = 16'hFFFF;
    @(negedge clk);
    release dut_a.r_sample_cnt;
    en_a = 1'b1;
    wait_for(1, 2000, ok);
    wait_for(0, 600, ok);
    chk("wrap_valid_seen", ok, 1'b1);
    chk("wrap_d3", d3_a, 32'hABCD0000);
    wait_for(1, 2000, ok);
    wait_for(0, 600, ok);
    chk("post_wrap_valid_seen", ok, 1'b1);
    chk("post_wrap_cnt", d3_a[15:0], 16'h0001);

    for (int i = 0; i < 5000 && !b_done; i++) @(negedge clk);
    chk("short_period_done", b_done, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Short sample period: every other trigger lands while busy.
  initial begin
    int tprev, tnow;
    bit seen;
    en_b = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    tprev = 0;
    for (int k = 1; k <= 4; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
        @(negedge clk);
        seen = valid_b;
      end
      chk($sformatf("sp300_valid%0d_seen", k), seen, 1'b1);
      tnow = cyc;
      if (k > 1) chk($sformatf("sp300_spacing%0d", k), tnow - tprev, 600);
      chk($sformatf("sp300_cnt%0d", k), d3_b[15:0], 16'(k));
      tprev = tnow;
    end
    b_done = 1'b1;
  end

endmodule
